// File: rtl/prtcl_chkr_pkg.sv
// Shared protocol-checker types: pending MMIO read info, the 3DW completion
// header layout and the completion-generator FSM states.
package prtcl_chkr_pkg;

  localparam int PCIE_TAG_WIDTH   = 10;
  localparam int PCIE_LEN_WIDTH   = 10;
  localparam int PCIE_REQID_WIDTH = 16;
  localparam int PCIE_ADDR_WIDTH  = 64;

  typedef struct packed {
    logic [PCIE_TAG_WIDTH-1:0]   tag;
    logic [PCIE_LEN_WIDTH-1:0]   dw0_len;
    logic [PCIE_REQID_WIDTH-1:0] requester_id;
    logic [PCIE_ADDR_WIDTH-1:0]  addr;
  } t_mmio_timeout_hdr_info;

  // DW0 sits in the low 32 bits, DW3 (unused for a 3DW header) in the top 32.
  typedef struct packed {
    logic [31:0]                 rsvd_dw3;
    logic [PCIE_REQID_WIDTH-1:0] requester_id;
    logic [7:0]                  tag_lo;
    logic                        rsvd_dw2;
    logic [6:0]                  lower_addr;
    logic [15:0]                 completer_id;
    logic [2:0]                  status;
    logic                        bcm;
    logic [11:0]                 byte_count;
    logic [2:0]                  fmt;
    logic [4:0]                  cpl_type;
    logic                        tag_9;
    logic [2:0]                  tc;
    logic                        tag_8;
    logic                        attr_hi;
    logic                        ln;
    logic                        th;
    logic                        td;
    logic                        ep;
    logic [1:0]                  attr;
    logic [1:0]                  at;
    logic [PCIE_LEN_WIDTH-1:0]   length;
  } t_cpl_hdr;

  localparam logic [2:0] CPL_FMT_NODATA = 3'b000;
  localparam logic [2:0] CPL_FMT_DATA   = 3'b010;
  localparam logic [4:0] CPL_TYPE       = 5'b01010;
  localparam logic [2:0] CPL_STS_SC     = 3'b000;
  localparam logic [2:0] CPL_STS_UR     = 3'b001;

  typedef enum logic [1:0] {
    CPL_IDLE,
    CPL_BUILD,
    CPL_SEND,
    CPL_ACK
  } t_cpl_gen_state;

endpackage

// File: rtl/cpl_hdr_builder.sv
// Combinational completion former: turns a pending read's info into a
// single-beat completion (header in tdata[127:0], payload from bit 128).
module cpl_hdr_builder
  import prtcl_chkr_pkg::*;
#(
  parameter int          TDATA_WIDTH      = 512,
  parameter logic [31:0] CPL_DATA_PATTERN = 32'hFFFF_FFFF,
  parameter logic [15:0] COMPLETER_ID     = 16'h0000,
  parameter int          MAX_CPL_DW       = 2
) (
  input  t_mmio_timeout_hdr_info   info,
  output logic [TDATA_WIDTH-1:0]   cpl_tdata
);

  t_cpl_hdr hdr;
  logic     with_data;
  logic     unused_addr_hi;

  assign unused_addr_hi = ^info.addr[PCIE_ADDR_WIDTH-1:7];

  // A zero length encodes 1024 DW, which is always beyond what we answer.
  assign with_data = (info.dw0_len != '0) &&
                     (info.dw0_len <= PCIE_LEN_WIDTH'(MAX_CPL_DW));

  always_comb begin
    hdr              = '0;
    hdr.fmt          = with_data ? CPL_FMT_DATA : CPL_FMT_NODATA;
    hdr.cpl_type     = CPL_TYPE;
    hdr.tag_9        = info.tag[9];
    hdr.tag_8        = info.tag[8];
    hdr.tag_lo       = info.tag[7:0];
    hdr.length       = with_data ? info.dw0_len : '0;
    hdr.completer_id = COMPLETER_ID;
    hdr.status       = with_data ? CPL_STS_SC : CPL_STS_UR;
    hdr.byte_count   = with_data ? {info.dw0_len, 2'b00} : 12'd4;
    hdr.requester_id = info.requester_id;
    hdr.lower_addr   = {info.addr[6:2], 2'b00};

    cpl_tdata        = '0;
    cpl_tdata[127:0] = hdr;
    for (int i = 0; i < MAX_CPL_DW; i++) begin
      if (with_data && (PCIE_LEN_WIDTH'(i) < info.dw0_len)) begin
        cpl_tdata[128 + 32*i +: 32] = CPL_DATA_PATTERN;
      end
    end
  end

endmodule

// File: rtl/mmio_timeout_cpl_gen.sv
// Synthesizes completions for timed-out MMIO reads and merges them into the
// AFU TX stream at packet boundaries; drops AFU packets while blocking.
module mmio_timeout_cpl_gen
  import prtcl_chkr_pkg::*;
#(
  parameter int          TDATA_WIDTH      = 512,
  parameter logic [31:0] CPL_DATA_PATTERN = 32'hFFFF_FFFF,
  parameter logic [15:0] COMPLETER_ID     = 16'h0000,
  parameter int          MAX_CPL_DW       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_next_pending_mmio_rdy,
  input  t_mmio_timeout_hdr_info i_mmio_timeout_info,
  input  logic                   i_blocking_traffic,
  output logic                   o_mmio_rd_rsp_ack,
  input  logic                   i_afu_tvalid,
  output logic                   o_afu_tready,
  input  logic [TDATA_WIDTH-1:0] i_afu_tdata,
  input  logic                   i_afu_tlast,
  output logic                   o_tx_tvalid,
  input  logic                   i_tx_tready,
  output logic [TDATA_WIDTH-1:0] o_tx_tdata,
  output logic                   o_tx_tlast,
  output logic [15:0]            o_cpl_gen_cnt
);

  t_cpl_gen_state         state_q, state_d;
  t_mmio_timeout_hdr_info info_q, info_d;
  logic                   afu_in_pkt_q, afu_in_pkt_d;
  logic                   drop_q, drop_d;
  logic                   cpl_in_reg_q, cpl_in_reg_d;
  logic                   tx_tvalid_q, tx_tvalid_d;
  logic                   tx_tlast_q, tx_tlast_d;
  logic [TDATA_WIDTH-1:0] tx_tdata_q, tx_tdata_d;
  logic                   ack_q, ack_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   out_load;
  logic                   drop_mode;
  logic                   afu_tready;
  logic                   afu_accept;
  logic [TDATA_WIDTH-1:0] cpl_tdata;

  cpl_hdr_builder #(
    .TDATA_WIDTH      (TDATA_WIDTH),
    .CPL_DATA_PATTERN (CPL_DATA_PATTERN),
    .COMPLETER_ID     (COMPLETER_ID),
    .MAX_CPL_DW       (MAX_CPL_DW)
  ) u_cpl_hdr_builder (
    .info      (info_q),
    .cpl_tdata (cpl_tdata)
  );

  assign out_load   = !tx_tvalid_q || i_tx_tready;
  // Drop decision is taken at the first beat and held for the whole packet.
  assign drop_mode  = afu_in_pkt_q ? drop_q : i_blocking_traffic;
  assign afu_accept = i_afu_tvalid && afu_tready;

  always_comb begin
    state_d      = state_q;
    info_d       = info_q;
    afu_in_pkt_d = afu_in_pkt_q;
    drop_d       = drop_q;
    cpl_in_reg_d = cpl_in_reg_q;
    tx_tvalid_d  = tx_tvalid_q;
    tx_tlast_d   = tx_tlast_q;
    tx_tdata_d   = tx_tdata_q;
    ack_d        = 1'b0;
    cnt_d        = cnt_q;
    afu_tready   = 1'b0;

    unique case (state_q)
      CPL_IDLE: begin
        afu_tready = drop_mode ? 1'b1 : out_load;
        if (out_load) begin
          tx_tvalid_d = i_afu_tvalid && !drop_mode;
          tx_tdata_d  = i_afu_tdata;
          tx_tlast_d  = i_afu_tlast;
        end
        if (i_next_pending_mmio_rdy && !afu_in_pkt_q && !(i_afu_tvalid && afu_tready)) begin
          info_d  = i_mmio_timeout_info;
          state_d = CPL_BUILD;
        end
      end
      CPL_BUILD: begin
        if (out_load) begin
          tx_tvalid_d  = 1'b1;
          tx_tdata_d   = cpl_tdata;
          tx_tlast_d   = 1'b1;
          cpl_in_reg_d = 1'b1;
        end
        state_d = CPL_SEND;
      end
      CPL_SEND: begin
        // Completion may still be waiting behind a stalled AFU beat.
        if (cpl_in_reg_q) begin
          if (tx_tvalid_q && i_tx_tready) begin
            tx_tvalid_d  = 1'b0;
            cpl_in_reg_d = 1'b0;
            ack_d        = 1'b1;
            state_d      = CPL_ACK;
          end
        end else if (out_load) begin
          tx_tvalid_d  = 1'b1;
          tx_tdata_d   = cpl_tdata;
          tx_tlast_d   = 1'b1;
          cpl_in_reg_d = 1'b1;
        end
      end
      CPL_ACK: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        state_d = CPL_IDLE;
      end
      default: state_d = CPL_IDLE;
    endcase

    if (afu_accept) begin
      afu_in_pkt_d = !i_afu_tlast;
      if (!afu_in_pkt_q) begin
        drop_d = i_blocking_traffic;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CPL_IDLE;
      info_q       <= '0;
      afu_in_pkt_q <= 1'b0;
      drop_q       <= 1'b0;
      cpl_in_reg_q <= 1'b0;
      tx_tvalid_q  <= 1'b0;
      tx_tlast_q   <= 1'b0;
      tx_tdata_q   <= '0;
      ack_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      info_q       <= info_d;
      afu_in_pkt_q <= afu_in_pkt_d;
      drop_q       <= drop_d;
      cpl_in_reg_q <= cpl_in_reg_d;
      tx_tvalid_q  <= tx_tvalid_d;
      tx_tlast_q   <= tx_tlast_d;
      tx_tdata_q   <= tx_tdata_d;
      ack_q        <= ack_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_afu_tready      = afu_tready;
  assign o_tx_tvalid       = tx_tvalid_q;
  assign o_tx_tdata        = tx_tdata_q;
  assign o_tx_tlast        = tx_tlast_q;
  assign o_mmio_rd_rsp_ack = ack_q;
  assign o_cpl_gen_cnt     = cnt_q;

endmodule
